// File: rtl/flash_rd_ctrl.sv
// Read-only NOR flash sequencer: power-up RESET# pulse, then timed
// CE#/OE# word reads driven by a valid/ready request port.
module flash_rd_ctrl #(
    parameter int ADDR_W        = 21,
    parameter int DATA_W        = 16,
    parameter int RST_PULSE_CYC = 13,
    parameter int RST_RECOV_CYC = 8,
    parameter int RD_WAIT_CYC   = 3,
    parameter int TURN_CYC      = 1
) (
    input  logic              clk25,
    input  logic              rst_,
    input  logic              flash_rst_req,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [ADDR_W-1:0] req_addr,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              busy,
    output logic              flash_reset_,
    output logic              flash_ce_,
    output logic              flash_oe_,
    output logic              flash_we_,
    output logic [ADDR_W-1:0] flash_a,
    input  logic [DATA_W-1:0] flash_dq_i
);

    localparam int M0 = (RST_PULSE_CYC > RST_RECOV_CYC) ?
                        RST_PULSE_CYC : RST_RECOV_CYC;
    localparam int M1 = (M0 > RD_WAIT_CYC) ? M0 : RD_WAIT_CYC;
    localparam int CNT_MAX = (M1 > TURN_CYC) ? M1 : TURN_CYC;
    localparam int CNT_W = $clog2(CNT_MAX + 1);

    localparam logic [CNT_W-1:0] PULSE_LD = CNT_W'(RST_PULSE_CYC - 1);
    localparam logic [CNT_W-1:0] RECOV_LD = CNT_W'(RST_RECOV_CYC - 1);
    localparam logic [CNT_W-1:0] WAIT_LD  = CNT_W'(RD_WAIT_CYC - 1);
    localparam logic [CNT_W-1:0] TURN_LD  =
        CNT_W'((TURN_CYC > 0) ? TURN_CYC - 1 : 0);

    typedef enum logic [2:0] {
        S_RST_LOW,
        S_RST_RECOV,
        S_IDLE,
        S_ACCESS,
        S_TURN
    } state_t;

    state_t             r_state;
    state_t             w_nxt_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_nxt_cnt;
    logic               w_req_ready;
    logic               w_accept;
    logic               w_done;

    logic               r_flash_rst_n;
    logic               r_ce_n;
    logic               r_oe_n;
    logic [ADDR_W-1:0]  r_addr;
    logic [DATA_W-1:0]  r_rsp_data;
    logic               r_rsp_valid;

    assign w_req_ready = (r_state == S_IDLE) & ~flash_rst_req;

    // Counter is reloaded on every state entry and saturates at zero.
    always_comb begin
        w_nxt_state = r_state;
        w_nxt_cnt   = (r_cnt != '0) ? r_cnt - 1'b1 : '0;
        w_accept    = 1'b0;
        w_done      = 1'b0;
        if (flash_rst_req) begin
            w_nxt_state = S_RST_LOW;
            w_nxt_cnt   = PULSE_LD;
        end else begin
            unique case (r_state)
                S_RST_LOW: begin
                    if (r_cnt == '0) begin
                        w_nxt_state = S_RST_RECOV;
                        w_nxt_cnt   = RECOV_LD;
                    end
                end
                S_RST_RECOV: begin
                    if (r_cnt == '0) begin
                        w_nxt_state = S_IDLE;
                        w_nxt_cnt   = '0;
                    end
                end
                S_IDLE: begin
                    w_nxt_cnt = '0;
                    if (req_valid) begin
                        w_accept    = 1'b1;
                        w_nxt_state = S_ACCESS;
                        w_nxt_cnt   = WAIT_LD;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == '0) begin
                        w_done      = 1'b1;
                        w_nxt_state = (TURN_CYC > 0) ? S_TURN : S_IDLE;
                        w_nxt_cnt   = TURN_LD;
                    end
                end
                S_TURN: begin
                    if (r_cnt == '0) begin
                        w_nxt_state = S_IDLE;
                        w_nxt_cnt   = '0;
                    end
                end
                default: begin
                    w_nxt_state = S_RST_LOW;
                    w_nxt_cnt   = PULSE_LD;
                end
            endcase
        end
    end

    always_ff @(posedge clk25 or negedge rst_) begin
        if (!rst_) begin
            r_state <= S_RST_LOW;
            r_cnt   <= PULSE_LD;
        end else begin
            r_state <= w_nxt_state;
            r_cnt   <= w_nxt_cnt;
        end
    end

    always_ff @(posedge clk25 or negedge rst_) begin
        if (!rst_) begin
            r_flash_rst_n <= 1'b0;
            r_ce_n        <= 1'b1;
            r_oe_n        <= 1'b1;
            r_addr        <= '0;
            r_rsp_data    <= '0;
            r_rsp_valid   <= 1'b0;
        end else begin
            r_flash_rst_n <= (w_nxt_state != S_RST_LOW);
            r_ce_n        <= (w_nxt_state != S_ACCESS);
            r_oe_n        <= (w_nxt_state != S_ACCESS);
            r_rsp_valid   <= w_done;
            if (w_accept) begin
                r_addr <= req_addr;
            end
            if (w_done) begin
                r_rsp_data <= flash_dq_i;
            end
        end
    end

    assign req_ready    = w_req_ready;
    assign rsp_valid    = r_rsp_valid;
    assign rsp_data     = r_rsp_data;
    assign busy         = (r_state != S_IDLE);
    assign flash_reset_ = r_flash_rst_n;
    assign flash_ce_    = r_ce_n;
    assign flash_oe_    = r_oe_n;
    assign flash_we_    = 1'b1;
    assign flash_a      = r_addr;

endmodule

// File: tb/tb_flash_rd_ctrl.sv
// Directed bench for flash_rd_ctrl with a behavioural NOR flash read model.
module tb_flash_rd_ctrl;

    logic        clk25 = 1'b0;
    logic        rst_;
    logic        flash_rst_req;
    logic        req_valid;
    logic        req_ready;
    logic [20:0] req_addr;
    logic        rsp_valid;
    logic [15:0] rsp_data;
    logic        busy;
    logic        flash_reset_;
    logic        flash_ce_;
    logic        flash_oe_;
    logic        flash_we_;
    logic [20:0] flash_a;
    logic [15:0] flash_dq_i;

    int checks = 0;
    int errors = 0;

    always #20 clk25 = ~clk25;

    flash_rd_ctrl dut (
        .clk25        (clk25),
        .rst_         (rst_),
        .flash_rst_req(flash_rst_req),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_addr     (req_addr),
        .rsp_valid    (rsp_valid),
        .rsp_data     (rsp_data),
        .busy         (busy),
        .flash_reset_ (flash_reset_),
        .flash_ce_    (flash_ce_),
        .flash_oe_    (flash_oe_),
        .flash_we_    (flash_we_),
        .flash_a      (flash_a),
        .flash_dq_i   (flash_dq_i)
    );

    function automatic logic [15:0] mem_word(input logic [20:0] a);
        if (a == 21'h1ABCD) return 16'h5A3C;
        return a[15:0] ^ {11'h0, a[20:16]} ^ 16'h1234;
    endfunction

    always_comb begin
        flash_dq_i = 16'hFFFF;
        if (!flash_ce_ && !flash_oe_) flash_dq_i = mem_word(flash_a);
    end

    // Called while observing the first RST_LOW cycle; returns in the
    // first cycle with req_ready high.
    task automatic reset_seq(input string tag);
        int   low_n;
        int   rec_n;
        logic pins_bad;
        logic glitch;
        logic rsp_seen;
        low_n = 0; rec_n = 0;
        pins_bad = 0; glitch = 0; rsp_seen = 0;
        for (int i = 0; i < 60; i++) begin
            if (flash_ce_ !== 1'b1 || flash_oe_ !== 1'b1 ||
                flash_we_ !== 1'b1) pins_bad = 1;
            if (rsp_valid !== 1'b0) rsp_seen = 1;
            if (req_ready === 1'b1) break;
            if (flash_reset_ === 1'b0) begin
                if (rec_n == 0) low_n++;
                else glitch = 1;
            end else begin
                rec_n++;
            end
            @(negedge clk25);
        end
        checks++;
        if (low_n !== 13) begin
            errors++;
            $display("FAIL %s rst_low_cycles got=%0d exp=13", tag, low_n);
        end
        checks++;
        if (rec_n !== 8 || glitch !== 1'b0) begin
            errors++;
            $display("FAIL %s recov_cycles got=%0d glitch=%0b exp=8/0",
                     tag, rec_n, glitch);
        end
        checks++;
        if (pins_bad !== 1'b0 || rsp_seen !== 1'b0) begin
            errors++;
            $display("FAIL %s pins_idle got bad=%0b rsp=%0b exp=0/0",
                     tag, pins_bad, rsp_seen);
        end
        checks++;
        if (req_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s ready_end got rdy=%0b busy=%0b exp=1/0",
                     tag, req_ready, busy);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        checks++;
        if (flash_reset_ !== 1'b0 || flash_ce_ !== 1'b1 ||
            flash_oe_ !== 1'b1 || flash_we_ !== 1'b1 ||
            flash_a !== 21'h0 || rsp_data !== 16'h0 ||
            rsp_valid !== 1'b0 || req_ready !== 1'b0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL %s reset_vals got rst=%0b ce=%0b oe=%0b we=%0b a=%h d=%h v=%0b rdy=%0b busy=%0b exp 0 1 1 1 0 0 0 0 1",
                     tag, flash_reset_, flash_ce_, flash_oe_, flash_we_,
                     flash_a, rsp_data, rsp_valid, req_ready, busy);
        end
    endtask

    task automatic test_reset();
        rst_ = 1'b0;
        flash_rst_req = 1'b0;
        req_valid = 1'b0;
        req_addr = '0;
        repeat (2) @(negedge clk25);
        #1;
        check_reset_vals("reset");
        @(negedge clk25);
        rst_ = 1'b1;
        #1;
        reset_seq("powerup");
    endtask

    task automatic test_single_read();
        int   ce_n;
        int   first_ce;
        int   rsp_n;
        int   rsp_k;
        logic [15:0] rsp_d;
        logic bad_a;
        ce_n = 0; first_ce = -1; rsp_n = 0; rsp_k = -1;
        rsp_d = '0; bad_a = 0;
        req_valid = 1'b1;
        req_addr  = 21'h1ABCD;
        for (int k = 1; k <= 8; k++) begin
            @(negedge clk25);
            req_valid = 1'b0;
            if (flash_ce_ !== flash_oe_) bad_a = 1;
            if (flash_ce_ === 1'b0) begin
                ce_n++;
                if (first_ce < 0) first_ce = k;
                if (flash_a !== 21'h1ABCD) bad_a = 1;
            end
            if (rsp_valid === 1'b1) begin
                rsp_n++;
                rsp_k = k;
                rsp_d = rsp_data;
            end
        end
        checks++;
        if (ce_n !== 3 || first_ce !== 1) begin
            errors++;
            $display("FAIL read ce_window got n=%0d first=%0d exp=3/1",
                     ce_n, first_ce);
        end
        checks++;
        if (bad_a !== 1'b0) begin
            errors++;
            $display("FAIL read addr_oe got bad=1 exp=0");
        end
        checks++;
        if (rsp_n !== 1 || rsp_k !== 4) begin
            errors++;
            $display("FAIL read rsp_timing got n=%0d k=%0d exp=1/4",
                     rsp_n, rsp_k);
        end
        checks++;
        if (rsp_d !== 16'h5A3C || rsp_data !== 16'h5A3C) begin
            errors++;
            $display("FAIL read rsp_data got %h/%h exp=5a3c", rsp_d, rsp_data);
        end
    endtask

    task automatic test_back_to_back();
        logic [20:0] addrs [3];
        int acc [3];
        int rsp_t [3];
        int idx;
        int ridx;
        int segs;
        logic prev_ce;
        addrs[0] = 21'h00000;
        addrs[1] = 21'h00001;
        addrs[2] = 21'h1FFFFF;
        for (int i = 0; i < 3; i++) begin
            acc[i] = -100;
            rsp_t[i] = -100;
        end
        idx = 0; ridx = 0; segs = 0; prev_ce = 1'b1;
        for (int t = 0; t < 25; t++) begin
            if (rsp_valid === 1'b1) begin
                if (ridx < 3) begin
                    rsp_t[ridx] = t;
                    checks++;
                    if (rsp_data !== mem_word(addrs[ridx])) begin
                        errors++;
                        $display("FAIL b2b rsp%0d_data got %h exp %h",
                                 ridx, rsp_data, mem_word(addrs[ridx]));
                    end
                end
                ridx++;
            end
            if (flash_ce_ === 1'b0 && prev_ce === 1'b1) segs++;
            prev_ce = flash_ce_;
            if (idx < 3) begin
                req_valid = 1'b1;
                req_addr  = addrs[idx];
                if (req_ready === 1'b1) begin
                    acc[idx] = t;
                    idx++;
                end
            end else begin
                req_valid = 1'b0;
            end
            @(negedge clk25);
        end
        req_valid = 1'b0;
        checks++;
        if (idx !== 3 || acc[1] - acc[0] !== 5 || acc[2] - acc[0] !== 10) begin
            errors++;
            $display("FAIL b2b accepts got n=%0d at %0d,%0d,%0d exp 3 at N,N+5,N+10",
                     idx, acc[0], acc[1], acc[2]);
        end
        checks++;
        if (ridx !== 3) begin
            errors++;
            $display("FAIL b2b rsp_count got %0d exp 3", ridx);
        end
        for (int i = 0; i < 3; i++) begin
            checks++;
            if (rsp_t[i] !== acc[i] + 4) begin
                errors++;
                $display("FAIL b2b rsp%0d_cycle got %0d exp %0d",
                         i, rsp_t[i], acc[i] + 4);
            end
        end
        checks++;
        if (segs !== 3) begin
            errors++;
            $display("FAIL b2b ce_segments got %0d exp 3", segs);
        end
    endtask

    task automatic test_abort_access();
        req_valid = 1'b1;
        req_addr  = 21'h0ABCD;
        @(negedge clk25);
        req_valid = 1'b0;
        checks++;
        if (flash_ce_ !== 1'b0) begin
            errors++;
            $display("FAIL abort ce_low got %0b exp 0", flash_ce_);
        end
        @(negedge clk25);
        flash_rst_req = 1'b1;
        @(negedge clk25);
        flash_rst_req = 1'b0;
        checks++;
        if (flash_ce_ !== 1'b1 || flash_oe_ !== 1'b1 ||
            flash_reset_ !== 1'b0) begin
            errors++;
            $display("FAIL abort pins got ce=%0b oe=%0b rst=%0b exp 1 1 0",
                     flash_ce_, flash_oe_, flash_reset_);
        end
        reset_seq("abort");
        checks++;
        if (rsp_data !== mem_word(21'h1FFFFF)) begin
            errors++;
            $display("FAIL abort rsp_held got %h exp %h",
                     rsp_data, mem_word(21'h1FFFFF));
        end
    endtask

    task automatic test_async_reset();
        req_valid = 1'b1;
        req_addr  = 21'h12345;
        @(negedge clk25);
        req_valid = 1'b0;
        @(negedge clk25);
        #5;
        rst_ = 1'b0;
        #1;
        check_reset_vals("async");
        repeat (2) @(negedge clk25);
        rst_ = 1'b1;
        #1;
        reset_seq("async_rel");
    endtask

    task automatic test_req_vs_rst();
        req_valid     = 1'b1;
        flash_rst_req = 1'b1;
        req_addr      = 21'h155555;
        #1;
        checks++;
        if (req_ready !== 1'b0) begin
            errors++;
            $display("FAIL collide req_ready got %0b exp 0", req_ready);
        end
        @(negedge clk25);
        req_valid     = 1'b0;
        flash_rst_req = 1'b0;
        checks++;
        if (flash_a !== 21'h0 || busy !== 1'b1) begin
            errors++;
            $display("FAIL collide state got a=%h busy=%0b exp 0/1",
                     flash_a, busy);
        end
        reset_seq("collide");
    endtask

    initial begin
        test_reset();
        test_single_read();
        test_back_to_back();
        test_abort_access();
        test_async_reset();
        test_req_vs_rst();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
